// File: rtl/stream_mux_pkg.sv
// Shared types and limits for the stream multiplexer / arbiter.
package stream_mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mux_mode_e;

    localparam int MAX_CHANNELS = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: rotate by ptr, priority-encode, rotate back.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SELW-1:0]     ptr,
    output logic [SELW-1:0]     gnt_idx,
    output logic                gnt_any
);

    localparam logic [SELW:0] CH = (SELW+1)'(CHANNELS);

    logic [2*CHANNELS-1:0] dbl;
    logic [CHANNELS-1:0]   rot;
    logic [SELW-1:0]       off;
    logic [SELW:0]         sum;

    always_comb begin
        dbl     = {req, req} >> ptr;
        rot     = dbl[CHANNELS-1:0];
        off     = '0;
        gnt_any = 1'b0;
        // Scan downward so the lowest rotated offset wins.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off     = i[SELW-1:0];
                gnt_any = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= CH) begin
            sum = sum - CH;
        end
        gnt_idx = sum[SELW-1:0];
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-way stream mux with explicit-select or round-robin grant and a
// single-entry registered output stage.
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 8,
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    input  logic                      out_ready,
    output logic                      sel_err
);

    localparam int            PADN = 1 << SELW;
    localparam logic [SELW:0] CH   = (SELW+1)'(CHANNELS);

    mux_mode_e        md;
    logic             load;
    logic             sel_ok;
    logic             gnt_any;
    logic             rr_any;
    logic [SELW-1:0]  gnt;
    logic [SELW-1:0]  rr_idx;
    logic [PADN-1:0]  vpad;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic             sel_err_q, sel_err_d;

    assign md = mux_mode_e'(mode);

    rr_arbiter #(
        .CHANNELS(CHANNELS),
        .SELW    (SELW)
    ) u_arb (
        .req    (in_valid),
        .ptr    (ptr_q),
        .gnt_idx(rr_idx),
        .gnt_any(rr_any)
    );

    always_comb begin
        load = !out_valid_q || out_ready;
        // Zero-extend so an out-of-range sel reads as "not valid".
        vpad = '0;
        vpad[CHANNELS-1:0] = in_valid;
        sel_ok  = {1'b0, sel} < CH;
        gnt     = '0;
        gnt_any = 1'b0;
        unique case (md)
            MODE_RR: begin
                gnt     = rr_idx;
                gnt_any = rr_any;
            end
            MODE_SEL: begin
                if (sel_ok && vpad[sel]) begin
                    gnt     = sel;
                    gnt_any = 1'b1;
                end
            end
        endcase

        in_ready = '0;
        if (rst_n && load && gnt_any) begin
            in_ready[gnt] = 1'b1;
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = gnt_any;
            if (gnt_any) begin
                out_data_d = in_data[gnt*WIDTH +: WIDTH];
                out_chan_d = gnt;
                if (md == MODE_RR) begin
                    ptr_d = (gnt == SELW'(CHANNELS - 1)) ? '0 : gnt + 1'b1;
                end
            end
        end
        sel_err_d = (md == MODE_SEL) && !sel_ok && load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: directed scenarios plus random traffic vs a model.
module tb_stream_mux_arb;

    localparam int W = 16;
    localparam int C = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mode = 1'b0;
    logic [2:0]   sel = '0;
    logic [7:0]   in_valid = '0;
    logic [127:0] in_data = '0;
    logic [7:0]   in_ready;
    logic         out_valid;
    logic [15:0]  out_data;
    logic [2:0]   out_chan;
    logic         out_ready = 1'b0;
    logic         sel_err;

    logic         mode5 = 1'b0;
    logic [2:0]   sel5 = '0;
    logic [4:0]   iv5 = '0;
    logic [79:0]  id5 = '0;
    logic [4:0]   ir5;
    logic         ov5;
    logic [15:0]  od5;
    logic [2:0]   oc5;
    logic         or5 = 1'b0;
    logic         se5;

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_valid;
    logic [15:0] m_data;
    int          m_chan;
    int          m_ptr;
    bit          m_err;
    bit          m_load;
    bit          m_any;
    int          m_g;
    logic [7:0]  m_rdy;
    logic [7:0]  obs_rdy;

    always #5 clk = ~clk;

    stream_mux_arb #(.WIDTH(W), .CHANNELS(C)) u8 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
        .out_ready(out_ready), .sel_err(sel_err)
    );

    stream_mux_arb #(.WIDTH(W), .CHANNELS(5)) u5 (
        .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5),
        .in_valid(iv5), .in_data(id5), .in_ready(ir5),
        .out_valid(ov5), .out_data(od5), .out_chan(oc5),
        .out_ready(or5), .sel_err(se5)
    );

    function automatic void model_reset();
        m_valid = 0;
        m_data  = '0;
        m_chan  = 0;
        m_ptr   = 0;
        m_err   = 0;
    endfunction

    function automatic void model_comb();
        int idx;
        m_load = !m_valid || out_ready;
        m_any  = 0;
        m_g    = 0;
        if (mode == 1'b0) begin
            if (int'(sel) < C && in_valid[sel]) begin
                m_any = 1;
                m_g   = int'(sel);
            end
        end else begin
            for (int k = 0; k < C; k++) begin
                idx = (m_ptr + k) % C;
                if (!m_any && in_valid[idx]) begin
                    m_any = 1;
                    m_g   = idx;
                end
            end
        end
        m_rdy = (m_load && m_any) ? 8'(1 << m_g) : 8'h00;
    endfunction

    function automatic void model_edge();
        if (m_load) begin
            m_valid = m_any;
            if (m_any) begin
                m_data = in_data[m_g*W +: W];
                m_chan = m_g;
                if (mode) m_ptr = (m_g + 1) % C;
            end
        end
        m_err = (mode == 1'b0) && (int'(sel) >= C) && m_load;
    endfunction

    task automatic cycle();
        #2;
        model_comb();
        obs_rdy = in_ready;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        in_valid = '0;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mode = 1'b1;
        in_valid = 8'hFF;
        out_ready = 1'b1;
        #2;
        n_tests++;
        if (in_ready !== 8'h00 || out_valid !== 1'b0 || out_data !== 16'h0
            || out_chan !== 3'd0 || sel_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state rdy=%h v=%b d=%h c=%0d e=%b want 00/0/0000/0/0",
                     in_ready, out_valid, out_data, out_chan, sel_err);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold v=%b rdy=%h want 0/00", out_valid, in_ready);
        end
    endtask

    task automatic test_sel();
        apply_reset();
        mode = 1'b0;
        sel = 3'd3;
        in_data = '0;
        in_data[3*W +: W] = 16'hABCD;
        in_valid = 8'h08;
        out_ready = 1'b1;
        cycle();
        n_tests++;
        if (obs_rdy !== 8'h08 || out_valid !== 1'b1 || out_data !== 16'hABCD
            || out_chan !== 3'd3) begin
            n_fail++;
            $display("FAIL sel_xfer rdy=%h v=%b d=%h c=%0d want 08/1/abcd/3",
                     obs_rdy, out_valid, out_data, out_chan);
        end
        in_valid = 8'h00;
        cycle();
        n_tests++;
        if (obs_rdy !== 8'h00 || out_valid !== 1'b0 || out_data !== 16'hABCD) begin
            n_fail++;
            $display("FAIL sel_idle rdy=%h v=%b d=%h want 00/0/abcd",
                     obs_rdy, out_valid, out_data);
        end
    endtask

    task automatic test_rr_rotation();
        apply_reset();
        mode = 1'b1;
        for (int k = 0; k < C; k++) in_data[k*W +: W] = 16'(k);
        in_valid = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_tests++;
            if (out_valid !== 1'b1 || out_chan !== 3'(i % C)
                || out_data !== 16'(i % C)) begin
                n_fail++;
                $display("FAIL rr_seq[%0d] v=%b c=%0d d=%h want 1/%0d/%0d",
                         i, out_valid, out_chan, out_data, i % C, i % C);
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        mode = 1'b1;
        for (int k = 0; k < C; k++) in_data[k*W +: W] = 16'(k);
        in_valid = 8'h44;
        out_ready = 1'b1;
        cycle();
        n_tests++;
        if (out_chan !== 3'd2 || out_data !== 16'd2 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first c=%0d d=%h want 2/0002", out_chan, out_data);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_tests++;
            if (obs_rdy !== 8'h00 || out_valid !== 1'b1 || out_data !== 16'd2
                || out_chan !== 3'd2) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] rdy=%h v=%b d=%h c=%0d want 00/1/0002/2",
                         i, obs_rdy, out_valid, out_data, out_chan);
            end
        end
        out_ready = 1'b1;
        cycle();
        n_tests++;
        if (obs_rdy !== 8'h40 || out_chan !== 3'd6 || out_data !== 16'd6) begin
            n_fail++;
            $display("FAIL bp_resume rdy=%h c=%0d d=%h want 40/6/0006",
                     obs_rdy, out_chan, out_data);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        mode = 1'b1;
        for (int k = 0; k < C; k++) in_data[k*W +: W] = 16'h0100 + 16'(k);
        out_ready = 1'b1;
        in_valid = 8'h80;
        cycle();
        n_tests++;
        if (out_chan !== 3'd7 || out_data !== 16'h0107) begin
            n_fail++;
            $display("FAIL wrap_ch7 c=%0d d=%h want 7/0107", out_chan, out_data);
        end
        in_valid = 8'h01;
        cycle();
        n_tests++;
        if (out_chan !== 3'd0 || out_data !== 16'h0100 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_ch0 c=%0d d=%h want 0/0100", out_chan, out_data);
        end
        in_valid = 8'h81;
        cycle();
        n_tests++;
        if (out_chan !== 3'd7) begin
            n_fail++;
            $display("FAIL wrap_fair c=%0d want 7", out_chan);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        mode = 1'b0;
        sel = 3'd1;
        in_data[1*W +: W] = 16'h1234;
        in_valid = 8'h02;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        in_valid = 8'h00;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 16'h1234) begin
            n_fail++;
            $display("FAIL arst_pre v=%b d=%h want 1/1234", out_valid, out_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || in_ready !== 8'h00) begin
            n_fail++;
            $display("FAIL arst_now v=%b d=%h rdy=%h want 0/0000/00",
                     out_valid, out_data, in_ready);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mode = 1'b1;
        for (int k = 0; k < C; k++) in_data[k*W +: W] = 16'(k);
        in_valid = 8'h24;
        out_ready = 1'b1;
        cycle();
        n_tests++;
        if (out_valid !== 1'b1 || out_chan !== 3'd2) begin
            n_fail++;
            $display("FAIL arst_first v=%b c=%0d want 1/2", out_valid, out_chan);
        end
    endtask

    task automatic test_sel_err();
        apply_reset();
        for (int k = 0; k < 5; k++) id5[k*W +: W] = 16'h0050 + 16'(k);
        mode5 = 1'b0;
        sel5 = 3'd6;
        iv5 = 5'h1F;
        or5 = 1'b1;
        #2;
        n_tests++;
        if (ir5 !== 5'h00) begin
            n_fail++;
            $display("FAIL selerr_rdy rdy=%h want 00", ir5);
        end
        @(posedge clk);
        #1;
        sel5 = 3'd2;
        n_tests++;
        if (se5 !== 1'b1 || ov5 !== 1'b0) begin
            n_fail++;
            $display("FAIL selerr_pulse e=%b v=%b want 1/0", se5, ov5);
        end
        #2;
        n_tests++;
        if (ir5 !== 5'h04) begin
            n_fail++;
            $display("FAIL selerr_next_rdy rdy=%h want 04", ir5);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (se5 !== 1'b0 || ov5 !== 1'b1 || oc5 !== 3'd2 || od5 !== 16'h0052) begin
            n_fail++;
            $display("FAIL selerr_clear e=%b v=%b c=%0d d=%h want 0/1/2/0052",
                     se5, ov5, oc5, od5);
        end
        mode5 = 1'b1;
        iv5 = 5'h10;
        @(posedge clk);
        #1;
        iv5 = 5'h01;
        n_tests++;
        if (oc5 !== 3'd4 || od5 !== 16'h0054) begin
            n_fail++;
            $display("FAIL ch5_wrap4 c=%0d d=%h want 4/0054", oc5, od5);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (oc5 !== 3'd0 || od5 !== 16'h0050 || ov5 !== 1'b1) begin
            n_fail++;
            $display("FAIL ch5_wrap0 c=%0d d=%h want 0/0050", oc5, od5);
        end
        iv5 = '0;
        or5 = 1'b0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            mode = 1'($urandom_range(0, 1));
            sel = 3'($urandom);
            in_valid = 8'($urandom) & 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < C; k++) in_data[k*W +: W] = 16'($urandom);
            cycle();
            n_tests++;
            if (obs_rdy !== m_rdy || out_valid !== m_valid || sel_err !== m_err
                || (m_valid && (out_data !== m_data || out_chan !== 3'(m_chan)))) begin
                n_fail++;
                $display("FAIL rand[%0d] rdy=%h/%h v=%b/%b d=%h/%h c=%0d/%0d e=%b/%b",
                         i, obs_rdy, m_rdy, out_valid, m_valid, out_data, m_data,
                         out_chan, m_chan, sel_err, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sel();
        test_rr_rotation();
        test_backpressure();
        test_wrap();
        test_async_reset();
        test_sel_err();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
